// File: rtl/pc_pkg.sv
// Shared types, default parameters and the alignment helper for the program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_REDIRECT,
    SEL_CALL,
    SEL_RET,
    SEL_HOLD
  } pc_sel_e;

  localparam int          PC_DEFAULT_WIDTH        = 64;
  localparam int          PC_DEFAULT_INSTR_BYTES  = 4;
  localparam logic [63:0] PC_DEFAULT_RESET_VECTOR = 64'h0;
  localparam int          PC_DEFAULT_RAS_DEPTH    = 4;
  localparam int          PC_MASK_WIDTH           = 128;

  // Clears the low log2(instr_bytes) bits; callers truncate to their own width.
  function automatic logic [PC_MASK_WIDTH-1:0] align_mask(input int instr_bytes);
    return ~(PC_MASK_WIDTH'(instr_bytes) - PC_MASK_WIDTH'(1));
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushes past capacity overwrite the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_DEFAULT_WIDTH,
  parameter int DEPTH = PC_DEFAULT_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] push_ptr;
  logic [CNT_W-1:0] count;

  assign push_ptr = top_ptr + PTR_W'(1);
  assign top_data = entries[top_ptr];
  assign empty    = (count == '0);
  assign full     = (count == MAX_COUNT);

  // Starting the pointer at all-ones makes the first push land in slot 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      top_ptr <= '1;
      count   <= '0;
    end else if (push) begin
      top_ptr <= push_ptr;
      if (count != MAX_COUNT) count <= count + CNT_W'(1);
    end else if (pop && count != '0) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) entries[push_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential/redirect/call/return selection and stall support.
// Define PC_RAS_EN to build the return-address stack; otherwise call/ret act as plain redirects.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_DEFAULT_WIDTH,
  parameter int               INSTR_BYTES  = PC_DEFAULT_INSTR_BYTES,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_DEFAULT_RESET_VECTOR),
  parameter int               RAS_DEPTH    = PC_DEFAULT_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [WIDTH-1:0] ALIGN = WIDTH'(align_mask(INSTR_BYTES));

  if (INSTR_BYTES < 1 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0) begin : g_bad_instr_bytes
    $error("pc_unit: INSTR_BYTES must be a power of two");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("pc_unit: RAS_DEPTH must be a power of two >= 2");
  end

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_next;

  assign pc_next_seq = pc + WIDTH'(INSTR_BYTES);

  // Redirect outranks stall so a pipeline flush is never dropped.
  always_comb begin
    sel = SEL_SEQ;
    if (redirect)   sel = SEL_REDIRECT;
    else if (stall) sel = SEL_HOLD;
    else if (call)  sel = SEL_CALL;
    else if (ret)   sel = SEL_RET;
  end

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;

  assign ras_push = (sel == SEL_CALL);
  assign ras_pop  = (sel == SEL_RET) && !ras_empty;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_next_seq),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                ras_err <= 1'b0;
    else if ((sel == SEL_RET) && ras_empty)    ras_err <= 1'b1;
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  always_comb begin
    pc_next = pc_next_seq;
    case (sel)
      SEL_REDIRECT, SEL_CALL: pc_next = target & ALIGN;
      SEL_HOLD:               pc_next = pc;
`ifdef PC_RAS_EN
      SEL_RET:                pc_next = ras_empty ? pc_next_seq : (ras_top & ALIGN);
`else
      SEL_RET:                pc_next = target & ALIGN;
`endif
      default:                pc_next = pc_next_seq;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc <= RESET_VECTOR;
    else        pc <= pc_next;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle/pipelined CPU datapath; the successor to the fixed 64-bit increment-only PC register. It holds the fetch address and selects the next one from sequential increment, branch/jump redirect, or a return-address stack (RAS). It also supports fetch stalls and reports RAS status. It feeds the instruction memory address and the link-register write path.

## Interface
- WIDTH, 64: PC and target width in bits.
- INSTR_BYTES, 4: sequential increment; power of two ≥ 1.
- RESET_VECTOR, 0: PC value loaded on reset.
- RAS_DEPTH, 4: return-address stack entries; power of two ≥ 2.

- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and RAS this cycle.
- redirect  input  1  taken branch/jump to `target`, no RAS effect.
- call  input  1  jump to `target` and push `pc + INSTR_BYTES`.
- ret  input  1  return: pop RAS and jump to popped address.
- target  input  WIDTH  redirect/call destination.
- pc  output  WIDTH  current fetch address (registered).
- pc_next_seq  output  WIDTH  `pc + INSTR_BYTES` (combinational; the link value).
- ras_empty  output  1  RAS holds no entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_err  output  1  sticky: ret issued with RAS empty.

## Operation
- Priority, highest first: reset, redirect, stall, call, ret, sequential.
- redirect: pc ← target; RAS unchanged; overrides stall (a flush must not be lost).
- stall (no redirect): pc, RAS and ras_err all hold; call/ret ignored.
- call: pc ← target; push pc_next_seq.
- ret (no call): if RAS non-empty, pc ← top entry and pop. If empty, pc ← pc_next_seq and ras_err ← 1.
- call and ret in the same cycle: call wins; ret is ignored.
- Sequential: pc ← pc + INSTR_BYTES.
- Arithmetic is modulo 2^WIDTH: `pc` at max value wraps to 0.
- Alignment: low log2(INSTR_BYTES) bits of target and of popped addresses are forced to 0 before loading.
- RAS overflow: a push when full overwrites the oldest entry (circular). The count saturates at RAS_DEPTH, ras_full stays 1, and no error is flagged.
- ras_err clears only on reset.

## Timing
- Reset (asynchronous assert): pc = RESET_VECTOR, RAS count = 0, ras_empty = 1, ras_full = 0, ras_err = 0. RAS entry contents are don't-care.
- Reset deassertion is synchronised externally. The first rising edge after release performs a normal update.
- Latency: controls sampled at edge N appear on pc after edge N (one cycle). pc_next_seq follows pc combinationally.
- ras_empty and ras_full are registered-state decodes, valid in the same cycle as pc.
- Reset asserted mid-operation: pc and the RAS return to reset values immediately, without waiting for a clock edge.

## Configuration
- PC_RAS_EN defined: the RAS is instantiated as described.
- PC_RAS_EN undefined: no RAS storage. call behaves as redirect with no push, and ret behaves as redirect to `target`. ras_empty is tied 1, ras_full tied 0, ras_err tied 0.

## Structure
- Package pc_pkg:
  - next-PC select enum (SEL_SEQ, SEL_REDIRECT, SEL_CALL, SEL_RET, SEL_HOLD);
  - default parameter constants;
  - an alignment-mask helper function.
- Sub-module pc_ras:
  - circular LIFO of RAS_DEPTH × WIDTH entries with a top pointer and a saturating count;
  - push/pop inputs, top-entry output, empty/full outputs, plus the same async active-low reset.
- pc_unit contains the priority decode, the PC register and ras_err.

## Test plan
- Reset with RESET_VECTOR=0x1000, then 3 free-running cycles → pc = 0x1000, 0x1004, 0x1008, 0x100C.
- redirect=1, target=0x2003 together with stall=1 → next pc = 0x2000 (aligned; redirect overrides stall).
- call target=0x3000 at pc=0x100, then ret two cycles later → pc 0x3000, 0x3004, 0x104; ras_empty back to 1.
- RAS_DEPTH=4, five nested calls, then five rets → first four rets return the 5th, 4th, 3rd and 2nd link addresses. The fifth ret goes sequential and raises ras_err, which stays 1.
- pc = 2^WIDTH−4 with no controls → pc wraps to 0. Assert reset asynchronously mid-cycle → pc = RESET_VECTOR before the next edge.
- Build without PC_RAS_EN: ret with target=0x500 → pc = 0x500, ras_err stays 0, ras_empty stays 1.
